// File: rtl/noc_flit_packetizer.sv
// noc_flit_packetizer: turns a packet request plus its data beats into a head/body/tail NoC flit stream with a registered output
module noc_flit_packetizer #(
  parameter int FLIT_W  = 66,
  parameter int DATA_W  = 64,
  parameter int ID_X_W  = 2,
  parameter int ID_Y_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int ORDER_W = 4,
  parameter int LEN_W   = 8,
  parameter int SRC_X   = 0,
  parameter int SRC_Y   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ID_X_W-1:0]  req_dst_x,
  input  logic [ID_Y_W-1:0]  req_dst_y,
  input  logic [TYPE_W-1:0]  req_type,
  input  logic [ORDER_W-1:0] req_order,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               d_valid,
  output logic               d_ready,
  input  logic [DATA_W-1:0]  d_data,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic [FLIT_W-1:0]  flit_data,
  output logic               busy,
  output logic [15:0]        pkt_cnt
);
  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic can_load, req_hs, d_hs, out_hs;
  logic [DATA_W-1:0] head_pl;
  assign can_load  = !flit_valid || flit_ready;
  assign req_ready = (state == IDLE) && can_load;
  assign d_ready   = (state == BODY) && can_load;
  assign req_hs    = req_valid && req_ready;
  assign d_hs      = d_valid && d_ready;
  assign out_hs    = flit_valid && flit_ready;
  assign head_pl   = DATA_W'({req_len, req_order, req_type, ID_Y_W'(SRC_Y), ID_X_W'(SRC_X),
                              req_dst_y, req_dst_x});
  // A fresh load in the same cycle as a drain overrides the flit_valid clear below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flit_valid <= 1'b0;
      flit_data  <= '0;
      busy       <= 1'b0;
      pkt_cnt    <= '0;
      cnt        <= '0;
    end else begin
      if (out_hs) flit_valid <= 1'b0;
      case (state)
        IDLE: if (req_hs) begin
          flit_valid <= 1'b1;
          flit_data  <= {2'b10, head_pl};
          cnt        <= req_len;
          busy       <= 1'b1;
          state      <= BODY;
        end
        BODY: if (d_hs) begin
          flit_valid <= 1'b1;
          flit_data  <= {(cnt == '0) ? 2'b01 : 2'b00, d_data};
          cnt        <= cnt - 1'b1;
          if (cnt == '0) state <= DRAIN;
        end
        DRAIN: if (out_hs) begin
          busy    <= 1'b0;
          pkt_cnt <= pkt_cnt + 16'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_flit_packetizer.sv
// tb_noc_flit_packetizer: directed stimulus with a queue-based flit model checked every cycle
module tb_noc_flit_packetizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_dst_x = '0, req_dst_y = '0, req_type = '0;
  logic [3:0]  req_order = '0;
  logic [7:0]  req_len = '0;
  logic        d_valid = 1'b0, d_ready;
  logic [63:0] d_data = '0;
  logic        flit_valid, flit_ready = 1'b1;
  logic [65:0] flit_data;
  logic        busy;
  logic [15:0] pkt_cnt;

  noc_flit_packetizer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_type(req_type),
    .req_order(req_order), .req_len(req_len),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, cyc = 0, rdy_mode = 0;

  always @(posedge clk) begin
    #1;
    flit_ready = (rdy_mode == 1) ? ~flit_ready : (rdy_mode == 0);
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Model: a packet is its head flit followed by len+1 beats, the last marked tail.
  logic [65:0] exp_q[$];
  int          left = 0;
  logic        exp_busy = 1'b0;
  logic [15:0] exp_pkt = '0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_data = '0;
  int          hs_cyc[$];
  logic [65:0] hs_dat[$];
  int          lo_cyc[$];

  function automatic logic [65:0] head_flit(input logic [1:0] dx, input logic [1:0] dy,
                                            input logic [1:0] t, input logic [3:0] o,
                                            input logic [7:0] l);
    logic [63:0] p;
    p = {42'd0, l, o, t, 2'd0, 2'd0, dy, dx};
    return {2'b10, p};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      left = 0;
      exp_busy = 1'b0;
      exp_pkt = '0;
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, exp_busy);
      check("pkt_cnt", pkt_cnt, exp_pkt);
      check("req_ready", req_ready, !exp_busy);
      check("d_ready", d_ready, (left > 0) && (!flit_valid || flit_ready));
      if (!busy) lo_cyc.push_back(cyc);
      if (prev_stall) begin
        check("stall_valid", flit_valid, 1);
        check("stall_data", flit_data, prev_data);
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(head_flit(req_dst_x, req_dst_y, req_type, req_order, req_len));
        left = int'(req_len) + 1;
        exp_busy = 1'b1;
      end
      if (d_valid && d_ready && left > 0) begin
        exp_q.push_back({(left == 1) ? 2'b01 : 2'b00, d_data});
        left--;
      end
      if (flit_valid && flit_ready) begin
        hs_cyc.push_back(cyc);
        hs_dat.push_back(flit_data);
        if (exp_q.size() == 0) fail_now("unexpected_flit");
        else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          check("flit", flit_data, e);
          if (e[65:64] == 2'b01) begin
            exp_busy = 1'b0;
            exp_pkt = exp_pkt + 16'd1;
          end
        end
      end
      prev_stall = flit_valid && !flit_ready;
      prev_data = flit_data;
    end
  end

  task automatic send_req(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] t,
                          input logic [3:0] o, input logic [7:0] l);
    logic hs;
    int n;
    n = 0;
    req_valid = 1'b1; req_dst_x = dx; req_dst_y = dy; req_type = t; req_order = o; req_len = l;
    do begin
      @(negedge clk); hs = req_ready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 200);
    req_valid = 1'b0;
    if (!hs) fail_now("req_timeout");
  endtask

  task automatic send_beats(input int cnt, input logic [63:0] base);
    logic hs;
    int n;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      d_valid = 1'b1;
      d_data = base + 64'(i);
      do begin
        @(negedge clk); hs = d_ready;
        @(posedge clk); #1; n++;
      end while (!hs && n < 200);
      if (!hs) fail_now("beat_timeout");
    end
    d_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((busy || flit_valid) && n < 500);
    if (busy || flit_valid) fail_now("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    hs_cyc.delete();
    hs_dat.delete();
    lo_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    logic [1:0] mk[5];
    mk = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_data", flit_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort mid-packet: head, body1, body2 delivered, body3 held in output reg
    clear_log();
    send_req(2'd3, 2'd1, 2'd2, 4'd5, 8'd3);
    send_beats(3, 64'h100);
    #1 rst_n = 1'b0;
    #1;
    check("abort_flit_valid", flit_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pkt_cnt", pkt_cnt, 0);
    check("abort_flits_before", hs_dat.size(), 3);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet
    clear_log();
    send_req(2'd1, 2'd2, 2'd1, 4'd3, 8'd0);
    send_beats(1, 64'hA5);
    wait_idle();
    check("b_count", hs_dat.size(), 2);
    check("b_head", hs_dat[0], 66'h2_0000_0000_0000_0D09);
    check("b_tail", hs_dat[1], 66'h1_0000_0000_0000_00A5);
    check("b_pkt_cnt", pkt_cnt, 1);

    // Four beats back to back at full throughput
    clear_log();
    send_req(2'd0, 2'd3, 2'd0, 4'd9, 8'd3);
    send_beats(4, 64'hB000);
    wait_idle();
    check("c_count", hs_dat.size(), 5);
    check("c_span", hs_cyc[4] - hs_cyc[0], 4);
    for (int i = 0; i < 5; i++) check("c_marker", hs_dat[i][65:64], mk[i]);

    // Output stalled every other cycle
    clear_log();
    rdy_mode = 1;
    send_req(2'd2, 2'd2, 2'd3, 4'd15, 8'd3);
    send_beats(4, 64'hC000);
    wait_idle();
    rdy_mode = 0;
    check("d_count", hs_dat.size(), 5);
    check("d_head", hs_dat[0], 66'h2_0000_0000_0000_FF0A);
    for (int i = 1; i < 5; i++) check("d_body", hs_dat[i][63:0], 64'hC000 + 64'(i - 1));
    check("d_tail_marker", hs_dat[4][65:64], 2'b01);

    // Two packets with req_valid and d_valid held high
    @(posedge clk); #1;
    clear_log();
    fork
      begin send_req(2'd1, 2'd1, 2'd0, 4'd0, 8'd1); send_req(2'd1, 2'd0, 2'd0, 4'd1, 8'd1); end
      begin send_beats(2, 64'hD0); send_beats(2, 64'hE0); end
    join
    wait_idle();
    check("e_count", hs_dat.size(), 6);
    check("e_gap", hs_cyc[3] - hs_cyc[2], 2);
    lows = 0;
    foreach (lo_cyc[i]) if (lo_cyc[i] > hs_cyc[2] && lo_cyc[i] < hs_cyc[3]) lows++;
    check("e_busy_low", lows, 1);
    check("e_pkt_cnt", pkt_cnt, 5);

    // Packet counter wrap
    force dut.pkt_cnt = 16'hFFFF;
    exp_pkt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_cnt;
    @(posedge clk); #1;
    send_req(2'd0, 2'd1, 2'd2, 4'd4, 8'd0);
    send_beats(1, 64'h77);
    wait_idle();
    check("f_wrap", pkt_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
